input_vc_buffer: RTL and testbench

INPUT_VC_BUFFER -- requirements
Module: input_vc_buffer

---
 rtl/input_vc_buffer.sv | 88 ++++++++
 tb/tb_input_vc_buffer.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/input_vc_buffer.sv
// Per-VC input FIFOs with fixed-priority (highest VC wins) head selection toward the router.
// Latency: 1 cycle from write to fout_*; backpressure: fin_ready_o[v] = !full[v], pop on fout_valid_o && fout_ready_i.
module input_vc_buffer #(
    parameter int N_VIRT_CHN = 2,
    parameter int BUFF_DEPTH = 4,
    parameter int FLIT_WIDTH = 34,
    localparam int VCW = (N_VIRT_CHN > 1) ? $clog2(N_VIRT_CHN) : 1,
    localparam int AW  = $clog2(BUFF_DEPTH),
    localparam int PW  = AW + 1
) (
    input  logic                  clk,
    input  logic                  arst,
    input  logic [FLIT_WIDTH-1:0] fin_data_i,
    input  logic [VCW-1:0]        fin_vc_i,
    input  logic                  fin_valid_i,
    output logic [N_VIRT_CHN-1:0] fin_ready_o,
    output logic [FLIT_WIDTH-1:0] fout_data_o,
    output logic [VCW-1:0]        fout_vc_o,
    output logic                  fout_valid_o,
    input  logic                  fout_ready_i
);

    logic [FLIT_WIDTH-1:0] mem_q    [N_VIRT_CHN][BUFF_DEPTH];
    logic [PW-1:0]         wr_ptr_q [N_VIRT_CHN];
    logic [PW-1:0]         wr_ptr_d [N_VIRT_CHN];
    logic [PW-1:0]         rd_ptr_q [N_VIRT_CHN];
    logic [PW-1:0]         rd_ptr_d [N_VIRT_CHN];
    logic [N_VIRT_CHN-1:0] empty;
    logic [N_VIRT_CHN-1:0] full;
    logic [N_VIRT_CHN-1:0] push_vec;
    logic [N_VIRT_CHN-1:0] pop_vec;
    logic [VCW-1:0]        sel_vc;

    // Status and selection come only from registered pointers, so nothing on fin_* reaches fout_* in the same cycle.
    always_comb begin
        empty  = '0;
        full   = '0;
        sel_vc = '0;
        for (int v = 0; v < N_VIRT_CHN; v++) begin
            empty[v] = (wr_ptr_q[v] == rd_ptr_q[v]);
            full[v]  = (wr_ptr_q[v][AW] != rd_ptr_q[v][AW]) &&
                       (wr_ptr_q[v][AW-1:0] == rd_ptr_q[v][AW-1:0]);
            if (!empty[v]) begin
                sel_vc = VCW'(v);
            end
        end
    end

    assign fin_ready_o  = ~full;
    assign fout_valid_o = |(~empty);
    assign fout_vc_o    = sel_vc;
    assign fout_data_o  = fout_valid_o ? mem_q[sel_vc][rd_ptr_q[sel_vc][AW-1:0]] : '0;

    always_comb begin
        push_vec = '0;
        pop_vec  = '0;
        for (int v = 0; v < N_VIRT_CHN; v++) begin
            push_vec[v] = fin_valid_i && (fin_vc_i == VCW'(v)) && !full[v];
            pop_vec[v]  = fout_valid_o && fout_ready_i && (sel_vc == VCW'(v));
            wr_ptr_d[v] = wr_ptr_q[v] + {{(PW-1){1'b0}}, push_vec[v]};
            rd_ptr_d[v] = rd_ptr_q[v] + {{(PW-1){1'b0}}, pop_vec[v]};
        end
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            for (int v = 0; v < N_VIRT_CHN; v++) begin
                wr_ptr_q[v] <= '0;
                rd_ptr_q[v] <= '0;
            end
        end else begin
            for (int v = 0; v < N_VIRT_CHN; v++) begin
                wr_ptr_q[v] <= wr_ptr_d[v];
                rd_ptr_q[v] <= rd_ptr_d[v];
            end
        end
    end

    // Storage is left unreset; empty pointers mask its contents.
    always_ff @(posedge clk) begin
        for (int v = 0; v < N_VIRT_CHN; v++) begin
            if (push_vec[v]) begin
                mem_q[v][wr_ptr_q[v][AW-1:0]] <= fin_data_i;
            end
        end
    end

endmodule

// File: tb/tb_input_vc_buffer.sv
// Bench for input_vc_buffer: constant vector table, directed corner sequences, and random traffic vs a queue model.
module tb_input_vc_buffer;

    logic        clk;
    logic        arst;
    logic [33:0] fin_data_i;
    logic [0:0]  fin_vc_i;
    logic        fin_valid_i;
    logic [1:0]  fin_ready_o;
    logic [33:0] fout_data_o;
    logic [0:0]  fout_vc_o;
    logic        fout_valid_o;
    logic        fout_ready_i;

    int tests = 0;
    int fails = 0;

    logic [33:0] q0[$];
    logic [33:0] q1[$];

    input_vc_buffer #(.N_VIRT_CHN(2), .BUFF_DEPTH(4), .FLIT_WIDTH(34)) dut (
        .clk          (clk),
        .arst         (arst),
        .fin_data_i   (fin_data_i),
        .fin_vc_i     (fin_vc_i),
        .fin_valid_i  (fin_valid_i),
        .fin_ready_o  (fin_ready_o),
        .fout_data_o  (fout_data_o),
        .fout_vc_o    (fout_vc_o),
        .fout_valid_o (fout_valid_o),
        .fout_ready_i (fout_ready_i)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct packed {
        logic        v;
        logic        vc;
        logic [33:0] d;
        logic        r;
        logic        ev;
        logic        evc;
        logic [33:0] ed;
        logic [1:0]  erdy;
    } vec_t;

    vec_t tbl[13];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Model view: the highest non-empty VC presents its oldest flit; a VC accepts while holding fewer than 4.
    task automatic check_model(input string tag);
        logic        ev;
        logic        evc;
        logic [33:0] ed;
        ev  = (q0.size() > 0) || (q1.size() > 0);
        evc = (q1.size() > 0);
        ed  = '0;
        if (q1.size() > 0) ed = q1[0];
        else if (q0.size() > 0) ed = q0[0];
        chk({tag, ".valid"}, 64'(fout_valid_o), 64'(ev));
        chk({tag, ".vc"},    64'(fout_vc_o),    64'(evc));
        chk({tag, ".data"},  64'(fout_data_o),  64'(ed));
        chk({tag, ".ready"}, 64'(fin_ready_o),  64'({q1.size() < 4, q0.size() < 4}));
    endtask

    // Called at a negedge: drive, check against the model, take one rising edge, advance the model.
    task automatic cyc(input string tag, input logic v, input logic vc, input logic [33:0] d, input logic r);
        logic pop_en;
        logic pop_vc;
        logic push_en;
        fin_valid_i  = v;
        fin_vc_i     = vc;
        fin_data_i   = d;
        fout_ready_i = r;
        #1;
        check_model(tag);
        pop_en  = r && ((q0.size() > 0) || (q1.size() > 0));
        pop_vc  = (q1.size() > 0);
        push_en = v && ((vc ? q1.size() : q0.size()) < 4);
        @(posedge clk);
        if (pop_en) begin
            if (pop_vc) void'(q1.pop_front());
            else        void'(q0.pop_front());
        end
        if (push_en) begin
            if (vc) q1.push_back(d);
            else    q0.push_back(d);
        end
        @(negedge clk);
    endtask

    task automatic idle(input string tag, input logic r);
        cyc(tag, 1'b0, 1'b0, 34'h0, r);
    endtask

    initial begin
        fin_valid_i  = 1'b0;
        fin_vc_i     = 1'b0;
        fin_data_i   = '0;
        fout_ready_i = 1'b0;
        arst         = 1'b1;
        #1;
        chk("rst.valid", 64'(fout_valid_o), 64'd0);
        chk("rst.data",  64'(fout_data_o),  64'd0);
        chk("rst.vc",    64'(fout_vc_o),    64'd0);
        chk("rst.ready", 64'(fin_ready_o),  64'd3);
        @(negedge clk);
        @(negedge clk);
        arst = 1'b0;

        // Single flit on VC0, then VC1 fill to full with rejected fifth write and in-order drain.
        tbl[0]  = '{1'b1, 1'b0, 34'h1_0000_00AA, 1'b1, 1'b0, 1'b0, 34'h0,           2'b11};
        tbl[1]  = '{1'b0, 1'b0, 34'h0,           1'b1, 1'b1, 1'b0, 34'h1_0000_00AA, 2'b11};
        tbl[2]  = '{1'b0, 1'b0, 34'h0,           1'b1, 1'b0, 1'b0, 34'h0,           2'b11};
        tbl[3]  = '{1'b1, 1'b1, 34'd1,           1'b0, 1'b0, 1'b0, 34'h0,           2'b11};
        tbl[4]  = '{1'b1, 1'b1, 34'd2,           1'b0, 1'b1, 1'b1, 34'd1,           2'b11};
        tbl[5]  = '{1'b1, 1'b1, 34'd3,           1'b0, 1'b1, 1'b1, 34'd1,           2'b11};
        tbl[6]  = '{1'b1, 1'b1, 34'd4,           1'b0, 1'b1, 1'b1, 34'd1,           2'b11};
        tbl[7]  = '{1'b1, 1'b1, 34'd5,           1'b0, 1'b1, 1'b1, 34'd1,           2'b01};
        tbl[8]  = '{1'b0, 1'b0, 34'h0,           1'b1, 1'b1, 1'b1, 34'd1,           2'b01};
        tbl[9]  = '{1'b0, 1'b0, 34'h0,           1'b1, 1'b1, 1'b1, 34'd2,           2'b11};
        tbl[10] = '{1'b0, 1'b0, 34'h0,           1'b1, 1'b1, 1'b1, 34'd3,           2'b11};
        tbl[11] = '{1'b0, 1'b0, 34'h0,           1'b1, 1'b1, 1'b1, 34'd4,           2'b11};
        tbl[12] = '{1'b0, 1'b0, 34'h0,           1'b1, 1'b0, 1'b0, 34'h0,           2'b11};
        for (int i = 0; i < 13; i++) begin
            fin_valid_i  = tbl[i].v;
            fin_vc_i     = tbl[i].vc;
            fin_data_i   = tbl[i].d;
            fout_ready_i = tbl[i].r;
            #1;
            chk($sformatf("tbl%0d.valid", i), 64'(fout_valid_o), 64'(tbl[i].ev));
            chk($sformatf("tbl%0d.vc", i),    64'(fout_vc_o),    64'(tbl[i].evc));
            chk($sformatf("tbl%0d.data", i),  64'(fout_data_o),  64'(tbl[i].ed));
            chk($sformatf("tbl%0d.ready", i), 64'(fin_ready_o),  64'(tbl[i].erdy));
            cyc($sformatf("tbl%0d.m", i), tbl[i].v, tbl[i].vc, tbl[i].d, tbl[i].r);
        end

        // Preemption: VC1 flit arrives while VC0 drains and wins the next cycle.
        cyc("pre.w0", 1'b1, 1'b0, 34'hA1, 1'b0);
        cyc("pre.w1", 1'b1, 1'b0, 34'hA2, 1'b0);
        cyc("pre.w2", 1'b1, 1'b0, 34'hA3, 1'b0);
        cyc("pre.pw", 1'b1, 1'b1, 34'hB1, 1'b1);
        chk("pre.vc",   64'(fout_vc_o),   64'd1);
        chk("pre.data", 64'(fout_data_o), 64'hB1);
        idle("pre.d0", 1'b1);
        chk("pre.res", 64'(fout_data_o), 64'hA2);
        idle("pre.d1", 1'b1);
        chk("pre.last", 64'(fout_data_o), 64'hA3);
        idle("pre.d2", 1'b1);
        idle("pre.d3", 1'b1);

        // Full VC0: same-cycle pop and push, push must be refused.
        for (int i = 0; i < 4; i++) cyc($sformatf("full.w%0d", i), 1'b1, 1'b0, 34'hC0 + 34'(i), 1'b0);
        chk("full.rdy", 64'(fin_ready_o), 64'b10);
        cyc("full.pp", 1'b1, 1'b0, 34'hDEAD, 1'b1);
        chk("full.occ3", 64'(fin_ready_o), 64'b11);
        cyc("full.push", 1'b1, 1'b0, 34'hBEEF, 1'b0);
        chk("full.occ4", 64'(fin_ready_o), 64'b10);
        for (int i = 0; i < 5; i++) idle($sformatf("full.d%0d", i), 1'b1);

        // Stream ten flits through VC0 to wrap pointers.
        for (int i = 0; i < 10; i++) cyc($sformatf("wrap.%0d", i), 1'b1, 1'b0, 34'h100 + 34'(i), 1'b1);
        idle("wrap.end", 1'b1);
        idle("wrap.mt", 1'b1);

        // Reset mid-operation with two flits in each VC.
        for (int i = 0; i < 4; i++) cyc($sformatf("ar.w%0d", i), 1'b1, 1'(i / 2), 34'h200 + 34'(i), 1'b0);
        arst = 1'b1;
        #1;
        chk("ar.valid", 64'(fout_valid_o), 64'd0);
        chk("ar.ready", 64'(fin_ready_o),  64'd3);
        chk("ar.data",  64'(fout_data_o),  64'd0);
        q0.delete();
        q1.delete();
        @(negedge clk);
        arst = 1'b0;
        idle("ar.post", 1'b1);
        cyc("ar.w", 1'b1, 1'b1, 34'h2_0000_0055, 1'b1);
        chk("ar.first", 64'(fout_data_o), 64'h2_0000_0055);
        idle("ar.d", 1'b1);
        idle("ar.mt", 1'b1);

        // Random traffic against the queue model.
        for (int i = 0; i < 600; i++) begin
            cyc("rnd", 1'($urandom_range(0, 99) < 60), 1'($urandom), {2'($urandom), 32'($urandom)},
                1'($urandom_range(0, 99) < 50));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
